// File: rtl/bk_mem_pkg.sv
// Shared types and helpers for the shared-SRAM arbiter: FSM states, PHY command
// bundle, byte-lane encodings and CPU-to-SRAM word address mapping.
package bk_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_VRD   = 3'd1,
        ST_CRD   = 3'd2,
        ST_CWR   = 3'd3,
        ST_CHOLD = 3'd4
    } mem_state_t;

    // One-hot access command for the pin stage; at most one of vrd/crd/cwr is set.
    typedef struct packed {
        logic vrd;
        logic crd;
        logic cwr;
        logic we;
    } phy_cmd_t;

    // Lane enables as {ub_n, lb_n}
    localparam logic [1:0] LANE_BOTH = 2'b00;
    localparam logic [1:0] LANE_HI   = 2'b01;
    localparam logic [1:0] LANE_LO   = 2'b10;
    localparam logic [1:0] LANE_NONE = 2'b11;

    function automatic logic [31:0] cpu_word_addr(input logic [14:0] word,
                                                  input int unsigned base);
        return (base << 15) | {17'b0, word};
    endfunction

endpackage

// File: rtl/bk_sram_phy.sv
// SRAM pin register stage: every pin is a flop loaded from the arbiter's
// one-hot command for the coming clock, so pins never see input glitches.
module bk_sram_phy
    import bk_mem_pkg::*;
#(
    parameter int unsigned AW = 17
) (
    input  logic          clk,
    input  logic          reset,
    input  phy_cmd_t      i_cmd,
    input  logic [AW-1:0] i_vid_a,
    input  logic [AW-1:0] i_cpu_a,
    input  logic          i_byte,
    input  logic          i_lane_sel,
    input  logic [15:0]   i_wdata,
    output logic [AW-1:0] o_sram_a,
    output logic [15:0]   o_sram_dq_o,
    output logic          o_sram_dq_oe,
    output logic          o_sram_we_n,
    output logic          o_sram_oe_n,
    output logic          o_sram_ub_n,
    output logic          o_sram_lb_n
);

    logic [1:0] w_wr_lanes;

    // Odd byte address lives in the upper lane
    always_comb begin
        w_wr_lanes = LANE_BOTH;
        if (i_byte) begin
            w_wr_lanes = i_lane_sel ? LANE_HI : LANE_LO;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_sram_a                   <= '0;
            o_sram_dq_o                <= '0;
            o_sram_dq_oe               <= 1'b0;
            o_sram_we_n                <= 1'b1;
            o_sram_oe_n                <= 1'b1;
            {o_sram_ub_n, o_sram_lb_n} <= LANE_NONE;
        end else begin
            o_sram_dq_oe <= i_cmd.cwr;
            o_sram_we_n  <= ~(i_cmd.cwr & i_cmd.we);
            o_sram_oe_n  <= ~(i_cmd.vrd | i_cmd.crd);
            if (i_cmd.vrd) begin
                o_sram_a                   <= i_vid_a;
                {o_sram_ub_n, o_sram_lb_n} <= LANE_BOTH;
            end else if (i_cmd.crd) begin
                o_sram_a                   <= i_cpu_a;
                {o_sram_ub_n, o_sram_lb_n} <= LANE_BOTH;
            end else if (i_cmd.cwr) begin
                o_sram_a                   <= i_cpu_a;
                o_sram_dq_o                <= i_wdata;
                {o_sram_ub_n, o_sram_lb_n} <= w_wr_lanes;
            end else begin
                {o_sram_ub_n, o_sram_lb_n} <= LANE_NONE;
            end
        end
    end

endmodule

// File: rtl/bk_mem_arbiter.sv
// Shared asynchronous SRAM arbiter: video scan-out has grant priority over the
// CPU bus; each grant runs a fixed ACC_CYC-clock SRAM cycle to completion.
module bk_mem_arbiter
    import bk_mem_pkg::*;
#(
    parameter int unsigned AW       = 17,
    parameter int unsigned ACC_CYC  = 2,
    parameter int unsigned CPU_BASE = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_rd,
    input  logic          cpu_wt,
    input  logic [15:0]   cpu_adr,
    input  logic          cpu_byte,
    input  logic [15:0]   cpu_data_i,
    output logic [15:0]   cpu_data_o,
    output logic          cpu_reply,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic [15:0]   vid_data,
    output logic [AW-1:0] sram_a,
    output logic [15:0]   sram_dq_o,
    output logic          sram_dq_oe,
    input  logic [15:0]   sram_dq_i,
    output logic          sram_we_n,
    output logic          sram_oe_n,
    output logic          sram_ub_n,
    output logic          sram_lb_n
);

    localparam logic [2:0] ACC_N = 3'(ACC_CYC);

    mem_state_t    r_state, w_state_next, w_arb_state;
    logic [2:0]    r_cnt;
    logic          r_vid_pend;
    logic [AW-1:0] r_vid_addr;
    logic [AW-1:0] w_vid_a, w_cpu_a;
    logic          w_strobe, w_cpu_unserved, w_vid_cand, w_done;
    logic          w_enter, w_vid_done, w_crd_done, w_reply_next;
    phy_cmd_t      w_cmd;

    assign w_strobe = cpu_rd | cpu_wt;
    assign w_done   = (r_cnt == ACC_N);
    assign w_vid_a  = vid_req ? vid_addr : r_vid_addr;
    assign w_cpu_a  = AW'(cpu_word_addr(cpu_adr[15:1], CPU_BASE));

    // Arbitration at the end of VRD only counts a request arriving now: the
    // pending flag is being consumed by the cycle that just finished.
    assign w_vid_cand     = (r_state == ST_VRD) ? vid_req : (r_vid_pend | vid_req);
    assign w_cpu_unserved = w_strobe & ~cpu_reply & (r_state != ST_CHOLD);

    always_comb begin
        w_arb_state = ST_IDLE;
        if (w_vid_cand) begin
            w_arb_state = ST_VRD;
        end else if (w_cpu_unserved) begin
            w_arb_state = cpu_wt ? ST_CWR : ST_CRD;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_enter      = 1'b0;
        w_vid_done   = 1'b0;
        w_crd_done   = 1'b0;
        w_reply_next = cpu_reply;
        unique case (r_state)
            ST_IDLE: begin
                w_state_next = w_arb_state;
                w_enter      = (w_arb_state != ST_IDLE);
            end
            ST_VRD: begin
                if (w_done) begin
                    w_vid_done   = 1'b1;
                    w_state_next = w_arb_state;
                    w_enter      = (w_arb_state != ST_IDLE);
                end
            end
            ST_CRD, ST_CWR: begin
                if (w_done) begin
                    w_crd_done   = (r_state == ST_CRD);
                    w_state_next = w_strobe ? ST_CHOLD : ST_IDLE;
                    w_reply_next = w_strobe;
                end
            end
            ST_CHOLD: begin
                if (!w_strobe) begin
                    w_state_next = ST_IDLE;
                    w_reply_next = 1'b0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_reply_next = 1'b0;
            end
        endcase
    end

    // Write strobe is low for clocks 1..ACC_CYC-1, and always on the entry clock
    always_comb begin
        w_cmd     = '0;
        w_cmd.vrd = (w_state_next == ST_VRD);
        w_cmd.crd = (w_state_next == ST_CRD);
        w_cmd.cwr = (w_state_next == ST_CWR);
        w_cmd.we  = w_cmd.cwr & (w_enter | (({1'b0, r_cnt} + 4'd1) < {1'b0, ACC_N}));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_vid_pend <= 1'b0;
            r_vid_addr <= '0;
            cpu_reply  <= 1'b0;
            cpu_data_o <= '0;
            vid_ack    <= 1'b0;
            vid_data   <= '0;
        end else begin
            r_state   <= w_state_next;
            cpu_reply <= w_reply_next;
            vid_ack   <= w_vid_done;
            if (w_enter) begin
                r_cnt <= 3'd1;
            end else if (r_state == ST_VRD || r_state == ST_CRD || r_state == ST_CWR) begin
                r_cnt <= r_cnt + 3'd1;
            end
            if (w_vid_done) begin
                r_vid_pend <= 1'b0;
            end else if (vid_req) begin
                r_vid_pend <= 1'b1;
            end
            if (vid_req) begin
                r_vid_addr <= vid_addr;
            end
            if (w_vid_done) begin
                vid_data <= sram_dq_i;
            end
            if (w_crd_done) begin
                cpu_data_o <= sram_dq_i;
            end
        end
    end

    bk_sram_phy #(
        .AW(AW)
    ) u_phy (
        .clk          (clk),
        .reset        (reset),
        .i_cmd        (w_cmd),
        .i_vid_a      (w_vid_a),
        .i_cpu_a      (w_cpu_a),
        .i_byte       (cpu_byte),
        .i_lane_sel   (cpu_adr[0]),
        .i_wdata      (cpu_data_i),
        .o_sram_a     (sram_a),
        .o_sram_dq_o  (sram_dq_o),
        .o_sram_dq_oe (sram_dq_oe),
        .o_sram_we_n  (sram_we_n),
        .o_sram_oe_n  (sram_oe_n),
        .o_sram_ub_n  (sram_ub_n),
        .o_sram_lb_n  (sram_lb_n)
    );

endmodule

// File: tb/tb_bk_mem_arbiter.sv
// Directed bench for bk_mem_arbiter with a behavioural async SRAM attached.
module tb_bk_mem_arbiter;
    import bk_mem_pkg::*;

    localparam int unsigned AW = 17;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_rd, cpu_wt, cpu_byte;
    logic [15:0]   cpu_adr, cpu_data_i, cpu_data_o;
    logic          cpu_reply;
    logic          vid_req, vid_ack;
    logic [AW-1:0] vid_addr;
    logic [15:0]   vid_data;
    logic [AW-1:0] sram_a;
    logic [15:0]   sram_dq_o, sram_dq_i;
    logic          sram_dq_oe, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n;

    logic [15:0] mem [0:(1<<AW)-1];
    int n_chk  = 0;
    int n_fail = 0;
    int we_low_cnt = 0;
    int ack_cnt    = 0;

    always #5 clk = ~clk;

    bk_mem_arbiter #(
        .AW(AW),
        .ACC_CYC(2),
        .CPU_BASE(0)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wt(cpu_wt), .cpu_adr(cpu_adr), .cpu_byte(cpu_byte),
        .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_reply(cpu_reply),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
        .sram_a(sram_a), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
        .sram_dq_i(sram_dq_i), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
        .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    assign sram_dq_i = (!sram_oe_n) ? mem[sram_a] : 16'h0000;

    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) begin
            if (!sram_ub_n) mem[sram_a][15:8] <= sram_dq_o[15:8];
            if (!sram_lb_n) mem[sram_a][7:0]  <= sram_dq_o[7:0];
        end
        if (!sram_we_n) we_low_cnt <= we_low_cnt + 1;
        if (vid_ack)    ack_cnt    <= ack_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; cpu_rd = 0; cpu_wt = 0; cpu_byte = 0; cpu_adr = '0;
        cpu_data_i = '0; vid_req = 0; vid_addr = '0;
        tick(); tick();
        n_chk++; if (cpu_reply !== 1'b0) begin n_fail++; $display("FAIL rst_reply: got %b exp 0", cpu_reply); end
        n_chk++; if (vid_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b exp 0", vid_ack); end
        n_chk++; if (cpu_data_o !== 16'h0) begin n_fail++; $display("FAIL rst_cdata: got %h exp 0", cpu_data_o); end
        n_chk++; if (vid_data !== 16'h0) begin n_fail++; $display("FAIL rst_vdata: got %h exp 0", vid_data); end
        n_chk++; if ({sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n} !== 4'b1111) begin
            n_fail++; $display("FAIL rst_ctl_n: got %b exp 1111", {sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n}); end
        n_chk++; if (sram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL rst_dq_oe: got %b exp 0", sram_dq_oe); end
        n_chk++; if (sram_a !== '0) begin n_fail++; $display("FAIL rst_addr: got %h exp 0", sram_a); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_cpu_read();
        mem[256] <= 16'o123456;
        cpu_adr = 16'o001000; cpu_byte = 0; cpu_rd = 1;
        tick();  // clock 1
        n_chk++; if (sram_oe_n !== 1'b0 || sram_a !== 17'd256) begin
            n_fail++; $display("FAIL rd_pins: got oe_n=%b a=%h exp oe_n=0 a=100", sram_oe_n, sram_a); end
        tick();  // clock 2
        n_chk++; if (cpu_reply !== 1'b0) begin n_fail++; $display("FAIL rd_early_reply: got %b exp 0", cpu_reply); end
        tick();  // clock 3
        n_chk++; if (cpu_reply !== 1'b1) begin n_fail++; $display("FAIL rd_reply: got %b exp 1", cpu_reply); end
        n_chk++; if (cpu_data_o !== 16'o123456) begin n_fail++; $display("FAIL rd_data: got %o exp 123456", cpu_data_o); end
        tick();
        n_chk++; if (cpu_reply !== 1'b1) begin n_fail++; $display("FAIL rd_hold: got %b exp 1", cpu_reply); end
        cpu_rd = 0;
        tick();
        n_chk++; if (cpu_reply !== 1'b0) begin n_fail++; $display("FAIL rd_drop: got %b exp 0", cpu_reply); end
        tick();
    endtask

    task automatic test_byte_write();
        int w0;
        mem[0] <= 16'h1234;
        tick();
        w0 = we_low_cnt;
        cpu_adr = 16'o000001; cpu_byte = 1; cpu_data_i = 16'h5A5A; cpu_wt = 1;
        tick();  // clock 1
        n_chk++; if ({sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe} !== 4'b0011) begin
            n_fail++; $display("FAIL bw_pins: got we_n,ub_n,lb_n,oe=%b exp 0011", {sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe}); end
        n_chk++; if (sram_dq_o !== 16'h5A5A || sram_a !== '0) begin
            n_fail++; $display("FAIL bw_bus: got d=%h a=%h exp d=5a5a a=0", sram_dq_o, sram_a); end
        tick();  // clock 2
        n_chk++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b1) begin
            n_fail++; $display("FAIL bw_we_rise: got we_n=%b oe=%b exp 1 1", sram_we_n, sram_dq_oe); end
        tick();  // clock 3
        n_chk++; if (cpu_reply !== 1'b1) begin n_fail++; $display("FAIL bw_reply: got %b exp 1", cpu_reply); end
        n_chk++; if (we_low_cnt - w0 !== 1) begin n_fail++; $display("FAIL bw_we_len: got %0d exp 1", we_low_cnt - w0); end
        n_chk++; if (mem[0] !== 16'h5A34) begin n_fail++; $display("FAIL bw_mem: got %h exp 5a34", mem[0]); end
        cpu_wt = 0; cpu_byte = 0;
        tick();
        n_chk++; if (cpu_reply !== 1'b0) begin n_fail++; $display("FAIL bw_drop: got %b exp 0", cpu_reply); end
        tick();
    endtask

    task automatic test_vid_cpu_same();
        mem[17'h10000] <= 16'hBEEF;
        mem[64]        <= 16'hCAFE;
        tick();
        vid_req = 1; vid_addr = 17'h10000; cpu_adr = 16'o000200; cpu_rd = 1;
        tick();  // clock 1
        vid_req = 0;
        n_chk++; if (sram_oe_n !== 1'b0 || sram_a !== 17'h10000) begin
            n_fail++; $display("FAIL vc_vid_first: got oe_n=%b a=%h exp 0 10000", sram_oe_n, sram_a); end
        tick(); tick();  // clock 3
        n_chk++; if (vid_ack !== 1'b1 || vid_data !== 16'hBEEF) begin
            n_fail++; $display("FAIL vc_ack: got ack=%b d=%h exp 1 beef", vid_ack, vid_data); end
        n_chk++; if (sram_a !== 17'd64 || cpu_reply !== 1'b0) begin
            n_fail++; $display("FAIL vc_crd_start: got a=%h reply=%b exp 40 0", sram_a, cpu_reply); end
        tick();  // clock 4
        n_chk++; if (vid_ack !== 1'b0 || cpu_reply !== 1'b0) begin
            n_fail++; $display("FAIL vc_c4: got ack=%b reply=%b exp 0 0", vid_ack, cpu_reply); end
        tick();  // clock 5
        n_chk++; if (cpu_reply !== 1'b1 || cpu_data_o !== 16'hCAFE) begin
            n_fail++; $display("FAIL vc_reply: got reply=%b d=%h exp 1 cafe", cpu_reply, cpu_data_o); end
        cpu_rd = 0;
        tick(); tick();
    endtask

    task automatic test_vid_in_chold();
        mem[32]        <= 16'h0F0F;
        mem[17'h1ABCD] <= 16'h7E57;
        tick();
        cpu_adr = 16'o000100; cpu_rd = 1;
        tick(); tick(); tick();  // clock 3: reply up, CHOLD
        n_chk++; if (cpu_reply !== 1'b1 || cpu_data_o !== 16'h0F0F) begin
            n_fail++; $display("FAIL ch_reply: got reply=%b d=%h exp 1 0f0f", cpu_reply, cpu_data_o); end
        vid_req = 1; vid_addr = 17'h1ABCD;
        tick();
        vid_req = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_chk++; if (sram_oe_n !== 1'b1 || vid_ack !== 1'b0 || cpu_reply !== 1'b1) begin
                n_fail++; $display("FAIL ch_quiet%0d: got oe_n=%b ack=%b reply=%b exp 1 0 1", i, sram_oe_n, vid_ack, cpu_reply); end
        end
        cpu_rd = 0;
        tick();  // IDLE
        n_chk++; if (cpu_reply !== 1'b0 || dut.r_state !== ST_IDLE) begin
            n_fail++; $display("FAIL ch_idle: got reply=%b st=%0d exp 0 0", cpu_reply, dut.r_state); end
        tick();  // IDLE+1: VRD
        n_chk++; if (sram_oe_n !== 1'b0 || sram_a !== 17'h1ABCD) begin
            n_fail++; $display("FAIL ch_vrd: got oe_n=%b a=%h exp 0 1abcd", sram_oe_n, sram_a); end
        tick();  // IDLE+2
        n_chk++; if (vid_ack !== 1'b0) begin n_fail++; $display("FAIL ch_ack_early: got %b exp 0", vid_ack); end
        tick();  // IDLE+3
        n_chk++; if (vid_ack !== 1'b1 || vid_data !== 16'h7E57) begin
            n_fail++; $display("FAIL ch_ack: got ack=%b d=%h exp 1 7e57", vid_ack, vid_data); end
        tick();
    endtask

    task automatic test_reset_mid_cwr();
        cpu_adr = 16'o000020; cpu_byte = 0; cpu_data_i = 16'hA5A5; cpu_wt = 1;
        tick();  // clock 1: CWR
        n_chk++; if (sram_we_n !== 1'b0) begin n_fail++; $display("FAIL rc_we: got %b exp 0", sram_we_n); end
        reset = 1;
        tick();
        n_chk++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
            n_fail++; $display("FAIL rc_pins: got we_n=%b oe=%b exp 1 0", sram_we_n, sram_dq_oe); end
        n_chk++; if (dut.r_state !== ST_IDLE || cpu_reply !== 1'b0) begin
            n_fail++; $display("FAIL rc_state: got st=%0d reply=%b exp 0 0", dut.r_state, cpu_reply); end
        reset = 0; cpu_wt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++; if (cpu_reply !== 1'b0 || sram_we_n !== 1'b1) begin
                n_fail++; $display("FAIL rc_after%0d: got reply=%b we_n=%b exp 0 1", i, cpu_reply, sram_we_n); end
        end
    endtask

    task automatic test_back_to_back();
        int a0;
        mem[17'h00100] <= 16'h1111;
        mem[17'h00200] <= 16'h2222;
        tick();
        a0 = ack_cnt;
        vid_req = 1; vid_addr = 17'h00100;
        tick();  // clock 1
        vid_addr = 17'h00200;
        tick();  // clock 2
        vid_req = 0;
        n_chk++; if (sram_a !== 17'h00200) begin n_fail++; $display("FAIL bb_addr: got %h exp 00200", sram_a); end
        tick();  // clock 3
        n_chk++; if (vid_ack !== 1'b1 || vid_data !== 16'h2222) begin
            n_fail++; $display("FAIL bb_ack: got ack=%b d=%h exp 1 2222", vid_ack, vid_data); end
        for (int i = 0; i < 5; i++) tick();
        n_chk++; if (ack_cnt - a0 !== 1) begin n_fail++; $display("FAIL bb_count: got %0d exp 1", ack_cnt - a0); end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_byte_write();
        test_vid_cpu_same();
        test_vid_in_chold();
        test_reset_mid_cwr();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bk_mem_arbiter.md
# bk_mem_arbiter

Arbiter and sequencer for the single shared asynchronous SRAM between two requesters: the CPU bus port of the core (read/write strobes, address, byte flag, reply) and the video scan-out fetcher. Each granted access runs as a fixed-length SRAM cycle and then returns data or an acknowledge. Video has priority at grant time so scan-out never underruns. The block sits between the core and the board SRAM pins and replaces direct wiring of the core's memory strobes to the chip.

## Interface
Parameters:
- `AW`, 17: SRAM word-address width.
- `ACC_CYC`, 2: clocks per SRAM access (1..7).
- `CPU_BASE`, 0: upper SRAM address bits prepended to CPU word addresses.

Ports:
- `clk` in 1: single system clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `cpu_rd` in 1: CPU read strobe. A level; held until `cpu_reply` is seen.
- `cpu_wt` in 1: CPU write strobe. Same rules as `cpu_rd`.
- `cpu_adr` in 16: CPU byte address. Bit 0 selects the lane when `cpu_byte`=1.
- `cpu_byte` in 1: byte access.
- `cpu_data_i` in 16: write data. The byte is already replicated on both lanes by the core.
- `cpu_data_o` out 16: read word, registered. Valid while `cpu_reply`=1.
- `cpu_reply` out 1: bus reply. Stays high until both strobes drop.
- `vid_req` in 1: video word request. Pulse or level.
- `vid_addr` in AW: video word address.
- `vid_ack` out 1: one-clock pulse. `vid_data` is valid in the same clock.
- `vid_data` out 16: registered read word.
- `sram_a` out AW: SRAM address.
- `sram_dq_o` out 16: SRAM write data.
- `sram_dq_oe` out 1: drive the data bus.
- `sram_dq_i` in 16: SRAM read data.
- `sram_we_n` out 1: write enable, active low.
- `sram_oe_n` out 1: output enable, active low.
- `sram_ub_n` out 1: upper byte-lane enable, active low.
- `sram_lb_n` out 1: lower byte-lane enable, active low.

## Operation
- States: IDLE, VRD, CRD, CWR, CHOLD.
- IDLE grant order, evaluated every clock:
  1. A pending video request goes to VRD.
  2. Otherwise a CPU request that has not yet been served goes to CRD (`cpu_rd`) or CWR (`cpu_wt`).
  3. Otherwise stay in IDLE.
- `vid_req` is latched into a pending flag together with `vid_addr`. A new `vid_req` while the flag is set overwrites the address; only one request is outstanding.
- The "CPU unserved" condition is: a strobe is high, `cpu_reply`=0, and the state is not CHOLD.
- VRD:
  - Drive `sram_a`=`vid_addr`, `oe_n`=0, `ub_n`=`lb_n`=0.
  - After ACC_CYC clocks, capture `sram_dq_i` into `vid_data`, pulse `vid_ack`, clear the pending flag, return to IDLE.
- CRD:
  - `sram_a` = {CPU_BASE, `cpu_adr[15:1]`}, truncated or zero-extended to AW.
  - `oe_n`=0 and both lanes enabled. Byte extraction is done by the core.
  - After ACC_CYC clocks, capture the data into `cpu_data_o`, set `cpu_reply`, go to CHOLD.
- CWR:
  - `dq_oe`=1 for the whole state. `we_n`=0 for clocks 1..ACC_CYC-1 of the state; with ACC_CYC=1 `we_n` is low for the single clock.
  - Lanes: word write gives `ub_n`=`lb_n`=0. Byte write gives `ub_n`=~`cpu_adr[0]` and `lb_n`=`cpu_adr[0]`.
  - `we_n` rises one clock before the address or data change. After ACC_CYC clocks, set `cpu_reply` and go to CHOLD.
- CHOLD: hold `cpu_reply`=1 until `cpu_rd`=`cpu_wt`=0, then clear `cpu_reply` and go to IDLE in the same clock. A video request that arrives during CHOLD stays pending; CHOLD is never preempted.
- No state preempts another. Once a cycle starts it completes.
- A strobe that drops mid CRD/CWR (core reset) does not abort the SRAM cycle. The reply is then cleared in the same clock it would have been set and the FSM returns to IDLE.
- `cpu_rd` and `cpu_wt` both high is illegal. Treat it as a write.

## Timing
- Reset values: state IDLE, `cpu_reply`=0, `vid_ack`=0, `cpu_data_o`=0, `vid_data`=0, `sram_we_n`=`oe_n`=`ub_n`=`lb_n`=1, `dq_oe`=0, `sram_a`=0, pending flag cleared. Reset mid-cycle forces these values in the next clock.
- All SRAM outputs are registered; no combinational path from inputs to pins.
- CPU read, no contention: strobe sampled at clock 0, CRD entered at clock 1, `cpu_reply` high at clock 1+ACC_CYC.
- CPU read, worst case behind a video grant: add ACC_CYC.
- Video: `vid_req` at clock 0, `vid_ack` at clock 1+ACC_CYC if IDLE. Worst case behind a CPU cycle is an extra ACC_CYC plus the CHOLD time.
- ACC_CYC is counted by a 3-bit counter that is reloaded on every state entry.

## Structure
- Package `bk_mem_pkg`:
  - state enum `mem_state_t`;
  - lane-encode constants;
  - function `cpu_word_addr` (CPU_BASE concatenation).
- Sub-module `bk_sram_phy`: pin registers, `dq_oe` and lane logic, driven by FSM one-hot commands. The FSM and arbitration stay in `bk_mem_arbiter`.

## Test plan
- Uncontended CPU word read at 0o001000 with SRAM model word 0o123456, ACC_CYC=2: `cpu_reply` at clock 3, `cpu_data_o`=0o123456, reply drops one clock after `cpu_rd` falls.
- CPU byte write to 0o000001 with data 0x5A5A: `ub_n`=0, `lb_n`=1, only the high byte of that word changes to 0x5A, `we_n` low for exactly 1 clock.
- `vid_req` and `cpu_rd` in the same clock: VRD runs first, `vid_ack` at clock 3, `cpu_reply` at clock 5.
- `vid_req` during CHOLD with the CPU holding its strobe for 10 clocks: no SRAM activity until the strobe drops, then `vid_ack` ACC_CYC+1 clocks after IDLE.
- `reset` asserted in the middle of CWR: the next clock shows `we_n`=1, `dq_oe`=0, state IDLE, and no reply pulse.
- Back-to-back `vid_req` pulses 1 clock apart: only one `vid_ack`, and it carries the second address's data.
